// File: rtl/serial_pad_scanner.sv
// Scans NES/SNES-style shift-register game pads in parallel and reports the
// button state of every pad plus the press/release edges once per frame.
module serial_pad_scanner #(
    parameter int NUM_PADS = 2,
    parameter int NUM_BITS = 8,
    parameter int DIV      = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [NUM_PADS-1:0]          data_in,
    output logic                         latch_out,
    output logic                         pad_clk_out,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic [NUM_PADS*NUM_BITS-1:0] released,
    output logic                         valid,
    output logic                         busy
);
    localparam int W  = NUM_PADS * NUM_BITS;
    localparam int CW = (2 * DIV > 1) ? $clog2(2 * DIV) : 1;
    localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [CW-1:0] LATCH_LAST = CW'(2 * DIV - 1);
    localparam logic [CW-1:0] PHASE_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(NUM_BITS - 1);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [BW-1:0] bit_reg, bit_next;
    logic          sample_en;
    logic          latch_reg, pad_clk_reg, valid_reg;
    logic [W-1:0]  shift_reg, shift_next;
    logic [W-1:0]  buttons_reg, pressed_reg, released_reg;

    // Each pad's field shifts left, so the first bit read ends up in its MSB.
    generate
        for (genvar gi = 0; gi < NUM_PADS; gi++) begin : g_pad
            assign shift_next[gi*NUM_BITS +: NUM_BITS] =
                {shift_reg[gi*NUM_BITS +: NUM_BITS-1], ~data_in[gi]};
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        bit_next   = bit_reg;
        sample_en  = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (start || continuous) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                if (cnt_reg == LATCH_LAST) begin
                    state_next = LOW;
                    cnt_next   = '0;
                    bit_next   = '0;
                end
            end
            LOW: begin
                if (cnt_reg == PHASE_LAST) begin
                    sample_en  = 1'b1;
                    cnt_next   = '0;
                    state_next = (bit_reg == BIT_LAST) ? DONE : HIGH;
                end
            end
            HIGH: begin
                if (cnt_reg == PHASE_LAST) begin
                    state_next = LOW;
                    cnt_next   = '0;
                    bit_next   = bit_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            latch_reg    <= 1'b0;
            pad_clk_reg  <= 1'b0;
            valid_reg    <= 1'b0;
            shift_reg    <= '0;
            buttons_reg  <= '0;
            pressed_reg  <= '0;
            released_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_reg     <= bit_next;
            // Pad strobes are decoded from the next state so they come straight off flops.
            latch_reg   <= (state_next == LATCH);
            pad_clk_reg <= (state_next == HIGH);
            valid_reg   <= (state_reg == DONE);
            if (sample_en) begin
                shift_reg <= shift_next;
            end
            if (state_reg == DONE) begin
                buttons_reg  <= shift_reg;
                pressed_reg  <= shift_reg & ~buttons_reg;
                released_reg <= ~shift_reg & buttons_reg;
            end
        end
    end

    assign latch_out   = latch_reg;
    assign pad_clk_out = pad_clk_reg;
    assign buttons     = buttons_reg;
    assign pressed     = pressed_reg;
    assign released    = released_reg;
    assign valid       = valid_reg;
    assign busy        = (state_reg != IDLE);
endmodule

// File: tb/tb_serial_pad_scanner.sv
// Scoreboard bench: two scanner instances (NES 2-pad DIV=4, SNES 1-pad DIV=1)
// driven by behavioural pad models; a monitor per instance checks each valid frame.
module tb_serial_pad_scanner;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, cont_a = 1'b0;
    logic [1:0]  data_a;
    logic        latch_a, pad_clk_a, valid_a, busy_a;
    logic [15:0] buttons_a, pressed_a, released_a;

    logic        start_b = 1'b0, cont_b = 1'b0;
    logic [0:0]  data_b;
    logic        latch_b, pad_clk_b, valid_b, busy_b;
    logic [11:0] buttons_b, pressed_b, released_b;

    serial_pad_scanner dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .continuous(cont_a),
        .data_in(data_a), .latch_out(latch_a), .pad_clk_out(pad_clk_a),
        .buttons(buttons_a), .pressed(pressed_a), .released(released_a),
        .valid(valid_a), .busy(busy_a)
    );

    serial_pad_scanner #(.NUM_PADS(1), .NUM_BITS(12), .DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .continuous(cont_b),
        .data_in(data_b), .latch_out(latch_b), .pad_clk_out(pad_clk_b),
        .buttons(buttons_b), .pressed(pressed_b), .released(released_b),
        .valid(valid_b), .busy(busy_b)
    );

    typedef struct {
        logic [15:0] b;
        logic [15:0] p;
        logic [15:0] r;
        int          cyc;
        int          lat;
        int          pc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Pad models: button bit NUM_BITS-1 is shifted out first, advancing on each pad clock rise.
    logic [7:0]  pad_btn_a [2];
    logic [11:0] pad_btn_b = '0;
    int   pulse_a = 0, pulse_b = 0;
    logic pd_model_a = 1'b0, pd_model_b = 1'b0;

    initial begin
        pad_btn_a[0] = '0;
        pad_btn_a[1] = '0;
    end

    always @(negedge clk) begin
        if (latch_a) pulse_a = 0;
        else if (pad_clk_a && !pd_model_a) pulse_a = pulse_a + 1;
        pd_model_a = pad_clk_a;
        if (latch_b) pulse_b = 0;
        else if (pad_clk_b && !pd_model_b) pulse_b = pulse_b + 1;
        pd_model_b = pad_clk_b;
    end

    always_comb begin
        data_a = 2'b11;
        for (int p = 0; p < 2; p++) begin
            if (pulse_a < 8) data_a[p] = ~pad_btn_a[p][7 - pulse_a];
        end
        data_b = 1'b1;
        if (pulse_b < 12) data_b[0] = ~pad_btn_b[11 - pulse_b];
    end

    // Monitors: count strobe activity per frame and compare each valid against the queue head.
    int   lat_a = 0, pc_a = 0, lat_b = 0, pc_b = 0;
    logic pd_a = 1'b0, pd_b = 1'b0;
    logic overlap_a = 1'b0, overlap_b = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            lat_a = 0;
            pc_a  = 0;
        end else begin
            if (latch_a && pad_clk_a) overlap_a = 1'b1;
            if (latch_a) lat_a++;
            if (pad_clk_a && !pd_a) pc_a++;
            pd_a = pad_clk_a;
            if (valid_a) begin
                if (qa.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL a_unexpected_valid: got valid with buttons=%h, expected none (cycle %0d)",
                             buttons_a, cyc);
                end else begin
                    e = qa.pop_front();
                    $display("pad A frame @%0d: buttons=%h pressed=%h released=%h latch=%0d clocks=%0d",
                             cyc, buttons_a, pressed_a, released_a, lat_a, pc_a);
                    check("a_buttons", int'(buttons_a), int'(e.b));
                    check("a_pressed", int'(pressed_a), int'(e.p));
                    check("a_released", int'(released_a), int'(e.r));
                    check("a_valid_cycle", cyc, e.cyc);
                    check("a_latch_cycles", lat_a, e.lat);
                    check("a_pad_clk_pulses", pc_a, e.pc);
                end
                lat_a = 0;
                pc_a  = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            lat_b = 0;
            pc_b  = 0;
        end else begin
            if (latch_b && pad_clk_b) overlap_b = 1'b1;
            if (latch_b) lat_b++;
            if (pad_clk_b && !pd_b) pc_b++;
            pd_b = pad_clk_b;
            if (valid_b) begin
                if (qb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL b_unexpected_valid: got valid with buttons=%h, expected none (cycle %0d)",
                             buttons_b, cyc);
                end else begin
                    e = qb.pop_front();
                    $display("pad B frame @%0d: buttons=%h pressed=%h released=%h latch=%0d clocks=%0d",
                             cyc, buttons_b, pressed_b, released_b, lat_b, pc_b);
                    check("b_buttons", int'(buttons_b), int'(e.b));
                    check("b_pressed", int'(pressed_b), int'(e.p));
                    check("b_released", int'(released_b), int'(e.r));
                    check("b_valid_cycle", cyc, e.cyc);
                    check("b_latch_cycles", lat_b, e.lat);
                    check("b_pad_clk_pulses", pc_b, e.pc);
                end
                lat_b = 0;
                pc_b  = 0;
            end
        end
    end

    task automatic frame_a(input logic [7:0] p0, input logic [7:0] p1,
                           input logic [15:0] eb, input logic [15:0] ep, input logic [15:0] er);
        @(negedge clk);
        pad_btn_a[0] = p0;
        pad_btn_a[1] = p1;
        qa.push_back('{b: eb, p: ep, r: er, cyc: cyc + 70, lat: 8, pc: 7});
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic frame_b(input logic [11:0] btn,
                           input logic [11:0] eb, input logic [11:0] ep, input logic [11:0] er);
        @(negedge clk);
        pad_btn_b = btn;
        qb.push_back('{b: 16'(eb), p: 16'(ep), r: 16'(er), cyc: cyc + 27, lat: 2, pc: 11});
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic drain(input bit use_b, input string name);
        int n = 0;
        while (((use_b ? qb.size() : qa.size()) != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, use_b ? qb.size() : qa.size(), 0);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_latch"}, int'(latch_a), 0);
        check({tag, "_pad_clk"}, int'(pad_clk_a), 0);
        check({tag, "_buttons"}, int'(buttons_a), 0);
        check({tag, "_pressed"}, int'(pressed_a), 0);
        check({tag, "_released"}, int'(released_a), 0);
        check({tag, "_valid"}, int'(valid_a), 0);
        check({tag, "_busy"}, int'(busy_a), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        check_a_zero("reset_a");
        check("reset_b_buttons", int'(buttons_b), 0);
        check("reset_b_busy", int'(busy_b), 0);
        check("reset_b_latch", int'(latch_b), 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_after_reset_busy", int'(busy_a), 0);

        // First frame after reset: A on pad 0, pad 1 idle.
        frame_a(8'h80, 8'h00, 16'h0080, 16'h0080, 16'h0000);
        drain(1'b0, "a_frame1_done");

        // Same input again, with start re-pulsed mid-frame (must be ignored).
        @(negedge clk);
        t0 = cyc;
        qa.push_back('{b: 16'h0080, p: 16'h0000, r: 16'h0000, cyc: t0 + 70, lat: 8, pc: 7});
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (19) @(negedge clk);
        check("busy_mid_frame", int'(busy_a), 1);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (19) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (28) @(negedge clk);
        check("busy_done_cycle", int'(busy_a), 1);
        @(negedge clk);
        check("busy_after_frame", int'(busy_a), 0);
        repeat (80) @(negedge clk);
        check("no_extra_frame_busy", int'(busy_a), 0);
        drain(1'b0, "a_frame2_done");

        // Release A.
        frame_a(8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0080);
        drain(1'b0, "a_frame3_done");

        // Continuous: three back-to-back frames, deasserted during the third.
        @(negedge clk);
        pad_btn_a[0] = 8'h05;
        pad_btn_a[1] = 8'hA3;
        t0 = cyc;
        qa.push_back('{b: 16'hA305, p: 16'hA305, r: 16'h0000, cyc: t0 + 70,  lat: 8, pc: 7});
        qa.push_back('{b: 16'hA305, p: 16'h0000, r: 16'h0000, cyc: t0 + 140, lat: 8, pc: 7});
        qa.push_back('{b: 16'hA305, p: 16'h0000, r: 16'h0000, cyc: t0 + 210, lat: 8, pc: 7});
        cont_a = 1'b1;
        repeat (150) @(negedge clk);
        cont_a = 1'b0;
        drain(1'b0, "a_continuous_done");
        repeat (100) @(negedge clk);
        check("continuous_stops_busy", int'(busy_a), 0);

        // Reset 30 cycles into a frame: everything clears at once, no valid.
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (29) @(negedge clk);
        check("pre_abort_busy", int'(busy_a), 1);
        reset_n = 1'b0;
        #1;
        check_a_zero("abort");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_abort_busy", int'(busy_a), 0);
        frame_a(8'h80, 8'h01, 16'h0180, 16'h0180, 16'h0000);
        drain(1'b0, "a_clean_frame_done");

        // SNES-style instance: 12 bits, one pad, DIV=1.
        frame_b(12'hFFF, 12'hFFF, 12'hFFF, 12'h000);
        drain(1'b1, "b_frame1_done");
        frame_b(12'hA5C, 12'hA5C, 12'h000, 12'h5A3);
        drain(1'b1, "b_frame2_done");

        repeat (20) @(negedge clk);
        check("a_latch_clk_overlap", int'(overlap_a), 0);
        check("b_latch_clk_overlap", int'(overlap_b), 0);
        check("a_queue_empty", qa.size(), 0);
        check("b_queue_empty", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/serial_pad_scanner.md
SERIAL_PAD_SCANNER -- requirements
Module: serial_pad_scanner

Interface
REQ-001 The block SHALL have parameter NUM_PADS, default 2: number of controllers scanned in parallel (legal 1..4).
REQ-002 The block SHALL have parameter NUM_BITS, default 8: button bits per controller (8 = NES, 12 = SNES; legal 2..16).
REQ-003 The block SHALL have parameter DIV, default 4: clk cycles per half pad-clock period (legal >= 1).
REQ-004 The block SHALL have port clk, input, 1: system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1: one-cycle request to scan one frame.
REQ-007 The block SHALL have port continuous, input, 1: when high, frames repeat back-to-back.
REQ-008 The block SHALL have port data_in, input, NUM_PADS: serial data per pad, active-low (0 = pressed), pre-synchronised externally.
REQ-009 The block SHALL have port latch_out, output, 1: shared latch to all pads, active-high.
REQ-010 The block SHALL have port pad_clk_out, output, 1: shared shift clock to all pads, idle low.
REQ-011 The block SHALL have port buttons, output, NUM_PADS*NUM_BITS: pad p occupies [p*NUM_BITS +: NUM_BITS]; 1 = pressed.
REQ-012 The block SHALL have port pressed, output, NUM_PADS*NUM_BITS: bits that went 0->1 in the latest frame.
REQ-013 The block SHALL have port released, output, NUM_PADS*NUM_BITS: bits that went 1->0 in the latest frame.
REQ-014 The block SHALL have port valid, output, 1: one-cycle strobe marking new buttons/pressed/released.
REQ-015 The block SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-016 The block SHALL implement states IDLE, LATCH, LOW, HIGH, DONE, with one cycle counter (0..2*DIV-1) and one bit index (0..NUM_BITS-1).
REQ-017 In IDLE, the block SHALL enter LATCH on the next edge when start=1 or continuous=1; otherwise it SHALL stay in IDLE.
REQ-018 LATCH SHALL last 2*DIV cycles with latch_out=1, then go to LOW with bit index 0.
REQ-019 LOW SHALL last DIV cycles with pad_clk_out=0; on its last cycle, the block SHALL sample ~data_in[p] into the shift register of every pad p at the current bit index.
REQ-020 After LOW, if bit index < NUM_BITS-1, the block SHALL go to HIGH; otherwise it SHALL go to DONE.
REQ-021 HIGH SHALL last DIV cycles with pad_clk_out=1, then go to LOW with bit index incremented; a frame therefore has NUM_BITS-1 clock pulses.
REQ-022 The first sampled bit SHALL land in the MSB of each pad's field and the last sampled bit in the LSB (NES: A,B,Select,Start,Up,Down,Left,Right = bits 7..0).
REQ-023 DONE SHALL last 1 cycle and return to IDLE; on that edge, buttons<=shift, pressed<=shift & ~buttons_old, released<=~shift & buttons_old, and valid<=1, all visible together in the following cycle.
REQ-024 valid SHALL be high for exactly one cycle per frame; pressed and released SHALL hold until the next valid.
REQ-025 Frame length from the first LATCH cycle to the DONE cycle inclusive SHALL be 2*DIV + NUM_BITS*DIV + (NUM_BITS-1)*DIV + 1 cycles (69 at defaults).
REQ-026 The block SHALL ignore start while busy=1, with no queuing.
REQ-027 The block SHALL complete the current frame if continuous is deasserted mid-frame; the next frame SHALL then require start.
REQ-028 latch_out and pad_clk_out SHALL be driven directly from flops (glitch-free), and SHALL never be high in the same cycle.
REQ-029 The first frame after reset SHALL report every pressed button in pressed (old state = 0).

Reset
REQ-030 While reset_n=0, outputs SHALL be: state IDLE, latch_out=0, pad_clk_out=0, buttons=0, pressed=0, released=0, valid=0, busy=0, and counters and shift registers 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately, with no valid and no partial update of buttons.
REQ-032 After reset_n deasserts, the block SHALL take no action until start=1 or continuous=1.

Verification
REQ-033 Bench SHALL cover default parameters, pad0 A pressed (data low in bit slot 0), pad1 idle, start pulse -> after 69 cycles valid=1, buttons=16'h0080, pressed=16'h0080, released=0.
REQ-034 Bench SHALL cover the same input held for a second frame -> buttons=16'h0080, pressed=0, released=0; then release A -> released=16'h0080 on the third frame.
REQ-035 Bench SHALL cover continuous=1 for 3 frames -> 3 valid strobes exactly 70 cycles apart, latch_out pulses of 8 cycles, 7 pad_clk_out pulses per frame.
REQ-036 Bench SHALL cover start pulsed during a frame -> no extra frame; busy stays high only to frame end.
REQ-037 Bench SHALL cover reset_n low at cycle 30 of a frame -> all outputs 0 immediately, no valid; the next start produces a clean 69-cycle frame.
REQ-038 Bench SHALL cover NUM_BITS=12, NUM_PADS=1, DIV=1, all buttons pressed -> valid after 2+12+11+1=26 cycles, buttons=12'hFFF.
